count_sched: RTL and testbench
==============================

# count_sched

Round-robin scheduler that shares one WIDTH-bit up/down counter among NREQ requesters. Each requester posts one operation (increment, decrement, load, clear) with a req/ack handshake. The scheduler arbitrates, sequences the operation through a three-state FSM and returns the resulting count to the winner. It sits between the free-running counter datapath and the blocks that need to modify or sample it, replacing direct enable/reset wiring.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 8, counter width in bits
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all state
- req  in  NREQ  per-requester request; bit i belongs to requester i
- op  in  2*NREQ  per-requester opcode, op[2i+1:2i]: 00 INC, 01 DEC, 10 LOAD, 11 CLR
- wdata  in  WIDTH*NREQ  per-requester load value, wdata[WIDTH*i +: WIDTH]
- freeze  in  1  stalls the EXEC state; counter holds its value
- ack  out  NREQ  one-cycle completion pulse, at most one bit set
- rdata  out  WIDTH  counter value after the acknowledged operation; valid while ack != 0
- count  out  WIDTH  current counter value, always visible
- gnt_id  out  clog2(NREQ)  index of the current grantee; valid while busy
- busy  out  1  high when the FSM is not in IDLE
- wrap  out  1  one-cycle pulse, coincident with ack, when INC overflowed or DEC underflowed

## Operation
- Reset values: state IDLE, count 0, rr pointer 0, ack 0, rdata 0, gnt_id 0, busy 0, wrap 0.
- IDLE: if req != 0, pick the winner.
  - Search starts at the rr pointer and moves upward with wrap-around; the first set bit wins.
  - Latch the winner's index, op and wdata, then go to EXEC.
  - If req == 0, stay in IDLE.
- EXEC:
  - If freeze = 1, stay in EXEC and hold count.
  - Otherwise apply the latched op and go to ACK:
    - INC: count+1 mod 2^WIDTH.
    - DEC: count-1 mod 2^WIDTH.
    - LOAD: count = latched wdata.
    - CLR: count = 0.
  - Register the wrap flag: INC from all-ones, or DEC from 0.
- ACK:
  - ack[gnt_id] = 1, rdata = count, wrap = registered flag.
  - rr pointer <= (gnt_id+1) mod NREQ.
  - Next state is IDLE.
- Requesters must hold req, op and wdata stable until ack. A requester drops req on the clock edge that ends its ack cycle.
- req/op/wdata sampled only in IDLE. Changes during EXEC/ACK are ignored.
- A req withdrawn before ack does not cancel the op. It completes and is acked anyway.
- Requests that arrive while busy wait for the next IDLE.
- Reset mid-operation: the FSM returns to IDLE immediately, no ack is issued, count is 0 and the pointer is 0. Requesters re-request.
- Arithmetic is unsigned, modulo 2^WIDTH. There is no saturation.

## Timing
- Cycle n: IDLE with req seen. Cycle n+1: EXEC. Cycle n+2: ACK (ack, rdata, wrap valid). Cycle n+3: IDLE again.
- Latency from req to ack is 2 cycles. Each freeze cycle in EXEC adds 1 cycle.
- Throughput is one operation per 3 cycles. Back-to-back grants have no idle gap beyond the IDLE sample cycle.
- count updates at the edge ending EXEC and is visible in the ACK cycle.
- ack, wrap, busy and gnt_id decode from registered state. There are no combinational paths from inputs to outputs.
- The grant is fair: with all requesters continuously active, each is served once every 3*NREQ cycles.

## Structure
- Package count_sched_pkg:
  - op encoding constants OP_INC, OP_DEC, OP_LOAD, OP_CLR.
  - State enum: IDLE, EXEC, ACK.
- Sub-module rr_arbiter: combinational rotating-priority pick.
  - Inputs: req vector and pointer.
  - Outputs: found flag and winner index.
  - Reusable elsewhere.
- count_sched contains the FSM, the latches, the counter register and the pointer register.

## Test plan
- Reset, then requester 0 alone sends INC three times -> acks at 2-cycle latency, rdata 1, 2, 3, with busy low for one cycle between operations.
- LOAD 8'hFF from requester 1, then INC from requester 2 -> rdata 8'hFF, then rdata 8'h00 with wrap = 1. Also: DEC from 0 -> 8'hFF with wrap = 1.
- All four req held high with INC -> grant order 0, 1, 2, 3, 0; each ack every 12 cycles; count increments by 1 per ack.
- Pointer at 2 with req = 4'b0011 -> requester 0 granted first, then requester 1.
- freeze held for 5 cycles during EXEC -> count unchanged, ack delayed by 5 cycles, result still correct.
- Assert reset in EXEC after LOAD 8'h5A -> no ack, count 0, state IDLE, pointer 0; the next request is served normally.

Source files
------------

// File: rtl/count_sched_pkg.sv
// count_sched_pkg: shared definitions for the counter scheduler.
//   OP_*     : per-requester opcode encoding
//   state_e  : scheduler FSM states
package count_sched_pkg;

  localparam logic [1:0] OP_INC  = 2'b00;
  localparam logic [1:0] OP_DEC  = 2'b01;
  localparam logic [1:0] OP_LOAD = 2'b10;
  localparam logic [1:0] OP_CLR  = 2'b11;

  // state | meaning
  // IDLE  | waiting for a request, winner picked and latched here
  // EXEC  | applying the latched op to the counter (held while frozen)
  // ACK   | one-cycle ack/rdata/wrap to the grantee, pointer advances
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    ACK  = 2'd2
  } state_e;

endpackage

// File: rtl/count_sched_if.sv
// count_sched_if: requester-side bundle of the counter scheduler.
//   master : requesters (drive req/op/wdata/freeze, observe results)
//   slave  : scheduler (observes requests, drives ack/rdata/count/gnt_id/busy/wrap)
interface count_sched_if #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [2*NREQ-1:0]     op;
  logic [WIDTH*NREQ-1:0] wdata;
  logic                  freeze;
  logic [NREQ-1:0]       ack;
  logic [WIDTH-1:0]      rdata;
  logic [WIDTH-1:0]      count;
  logic [IDW-1:0]        gnt_id;
  logic                  busy;
  logic                  wrap;

  modport master (
    output req, op, wdata, freeze,
    input  ack, rdata, count, gnt_id, busy, wrap
  );

  modport slave (
    input  req, op, wdata, freeze,
    output ack, rdata, count, gnt_id, busy, wrap
  );

endinterface

// File: rtl/count_sched_rr_arbiter.sv
// rr_arbiter: combinational rotating-priority pick.
//   req_i   : request vector
//   ptr_i   : index with highest priority this cycle
//   found_o : at least one request present
//   idx_o   : first set request at or above ptr_i, wrapping around
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req_i,
  input  logic [IDW-1:0] ptr_i,
  output logic           found_o,
  output logic [IDW-1:0] idx_o
);

  int best;

  // The winner is the set request with the smallest rotational distance
  // from the pointer.
  always_comb begin
    found_o = 1'b0;
    idx_o   = '0;
    best    = N;
    for (int i = 0; i < N; i++) begin
      if (req_i[i] && (((i - int'(ptr_i) + N) % N) < best)) begin
        best    = (i - int'(ptr_i) + N) % N;
        idx_o   = IDW'(i);
        found_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/count_sched.sv
// count_sched: round-robin scheduler sharing one up/down counter.
//   clk, reset : rising-edge clock, async active-high reset
//   bus        : requester bundle (slave side), see count_sched_if
module count_sched
  import count_sched_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         reset,
  count_sched_if.slave bus
);

  localparam int IDW = $clog2(NREQ);

  state_e           state_q, state_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic [IDW-1:0]   gnt_q, gnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;

  logic             found;
  logic [IDW-1:0]   win_idx;
  logic [1:0]       op_sel;
  logic [WIDTH-1:0] wdata_sel;

  rr_arbiter #(.N(NREQ), .IDW(IDW)) u_arb (
    .req_i  (bus.req),
    .ptr_i  (ptr_q),
    .found_o(found),
    .idx_o  (win_idx)
  );

  always_comb begin
    op_sel    = '0;
    wdata_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_idx == IDW'(i)) begin
        op_sel    = bus.op[2*i +: 2];
        wdata_sel = bus.wdata[WIDTH*i +: WIDTH];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    op_d    = op_q;
    wdata_d = wdata_q;
    count_d = count_q;
    wrap_d  = wrap_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = win_idx;
          op_d    = op_sel;
          wdata_d = wdata_sel;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (!bus.freeze) begin
          wrap_d = 1'b0;
          case (op_q)
            OP_INC: begin
              count_d = count_q + WIDTH'(1);
              wrap_d  = &count_q;
            end
            OP_DEC: begin
              count_d = count_q - WIDTH'(1);
              wrap_d  = ~|count_q;
            end
            OP_LOAD: count_d = wdata_q;
            default: count_d = '0;
          endcase
          state_d = ACK;
        end
      end
      ACK: begin
        // NREQ need not be a power of two, so wrap the pointer explicitly.
        ptr_d   = (gnt_q == IDW'(NREQ - 1)) ? '0 : gnt_q + IDW'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      op_q    <= '0;
      wdata_q <= '0;
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      op_q    <= op_d;
      wdata_q <= wdata_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  // All outputs decode from registered state only.
  assign bus.ack    = (state_q == ACK) ? (NREQ'(1) << gnt_q) : '0;
  assign bus.rdata  = (state_q == ACK) ? count_q : '0;
  assign bus.wrap   = (state_q == ACK) && wrap_q;
  assign bus.busy   = (state_q != IDLE);
  assign bus.gnt_id = gnt_q;
  assign bus.count  = count_q;

endmodule

// File: tb/tb_count_sched.sv
// tb_count_sched: self-checking bench for count_sched, transaction-level
// reference model (pending-request table, counter value, rr pointer).
module tb_count_sched;
  import count_sched_pkg::*;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int MOD   = 1 << WIDTH;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  count_sched_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  count_sched #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // reference model
  int       m_count;
  int       m_ptr;
  bit       pend[NREQ];
  bit [1:0] pop[NREQ];
  int       pwd[NREQ];
  int       last_ack[NREQ];
  bit       period_chk;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    logic [NREQ-1:0]       r;
    logic [2*NREQ-1:0]     o;
    logic [WIDTH*NREQ-1:0] w;
    r = '0; o = '0; w = '0;
    for (int i = 0; i < NREQ; i++) begin
      r[i]               = pend[i];
      o[2*i +: 2]        = pop[i];
      w[WIDTH*i +: WIDTH] = pwd[i][WIDTH-1:0];
    end
    bus.req   = r;
    bus.op    = o;
    bus.wdata = w;
  endtask

  task automatic post(input int i, input bit [1:0] o, input int wd);
    pend[i] = 1'b1;
    pop[i]  = o;
    pwd[i]  = wd;
    drive();
  endtask

  function automatic int pick();
    for (int k = 0; k < NREQ; k++)
      if (pend[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    return -1;
  endfunction

  // Entered at the falling edge of an IDLE cycle; returns at the falling
  // edge of the next IDLE cycle.
  task automatic serve(input int nfrz, input bit withdraw, input bit repost);
    int w;
    int exp_c;
    bit exp_w;
    w = pick();
    if (w < 0) begin
      chk("idle_busy", bus.busy, 0);
      chk("idle_count", bus.count, m_count);
      @(negedge clk);
      return;
    end
    chk("idle_busy", bus.busy, 0);
    chk("idle_ack", bus.ack, 0);
    exp_w = 1'b0;
    case (pop[w])
      OP_INC: begin
        exp_c = (m_count + 1) % MOD;
        exp_w = (m_count == MOD - 1);
      end
      OP_DEC: begin
        exp_c = (m_count + MOD - 1) % MOD;
        exp_w = (m_count == 0);
      end
      OP_LOAD: exp_c = pwd[w] % MOD;
      default: exp_c = 0;
    endcase
    @(negedge clk);
    chk("exec_busy", bus.busy, 1);
    chk("exec_gnt", bus.gnt_id, w);
    chk("exec_ack", bus.ack, 0);
    if (withdraw) begin
      pend[w] = 1'b0;
      drive();
    end
    for (int f = 0; f < nfrz; f++) begin
      bus.freeze = 1'b1;
      @(negedge clk);
      chk("frz_count", bus.count, m_count);
      chk("frz_ack", bus.ack, 0);
    end
    bus.freeze = 1'b0;
    @(negedge clk);
    chk("ack_vec", bus.ack, 1 << w);
    chk("ack_rdata", bus.rdata, exp_c);
    chk("ack_wrap", bus.wrap, exp_w);
    chk("ack_count", bus.count, exp_c);
    if (period_chk && last_ack[w] >= 0) chk("rr_period", cyc - last_ack[w], 3 * NREQ);
    last_ack[w] = cyc;
    m_count = exp_c;
    m_ptr   = (w + 1) % NREQ;
    pend[w] = repost;
    drive();
    @(negedge clk);
    chk("post_ack", bus.ack, 0);
  endtask

  initial begin
    m_count = 0;
    m_ptr   = 0;
    period_chk = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0; pop[i] = OP_INC; pwd[i] = 0; last_ack[i] = -1;
    end
    bus.freeze = 1'b0;
    drive();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    chk("rst_count", bus.count, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ack", bus.ack, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_gnt", bus.gnt_id, 0);
    chk("rst_wrap", bus.wrap, 0);

    // requester 0 alone, three INCs
    post(0, OP_INC, 0);
    serve(0, 0, 1);
    serve(0, 0, 1);
    serve(0, 0, 0);

    // LOAD FF, INC wraps to 00, DEC wraps to FF
    post(1, OP_LOAD, 8'hFF);
    serve(0, 0, 0);
    post(2, OP_INC, 0);
    serve(0, 0, 0);
    post(3, OP_DEC, 0);
    serve(0, 0, 0);

    // bring pointer to 2, then req = 0011
    post(1, OP_INC, 0);
    serve(0, 0, 0);
    chk("ptr_setup", m_ptr, 2);
    post(0, OP_INC, 0);
    post(1, OP_INC, 0);
    serve(0, 0, 0);
    serve(0, 0, 0);

    // freeze five cycles during EXEC
    post(2, OP_LOAD, 8'h33);
    serve(5, 0, 0);

    // reset while in EXEC after LOAD 5A
    post(3, OP_LOAD, 8'h5A);
    @(negedge clk);
    chk("rst_exec_busy", bus.busy, 1);
    reset = 1'b1;
    #1;
    chk("rst_mid_count", bus.count, 0);
    chk("rst_mid_busy", bus.busy, 0);
    chk("rst_mid_ack", bus.ack, 0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    drive();
    m_count = 0;
    m_ptr   = 0;
    @(negedge clk);
    chk("post_rst_ack", bus.ack, 0);
    post(1, OP_INC, 0);
    post(3, OP_INC, 0);
    serve(0, 0, 0);
    serve(0, 0, 0);

    // all requesters continuously active
    for (int i = 0; i < NREQ; i++) begin
      post(i, OP_INC, 0);
      last_ack[i] = -1;
    end
    period_chk = 1'b1;
    for (int n = 0; n < 2 * NREQ + 1; n++) serve(0, 0, 1);
    period_chk = 1'b0;
    for (int i = 0; i < NREQ; i++) pend[i] = 1'b0;
    drive();

    // randomized traffic
    for (int n = 0; n < 80; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          case ($urandom_range(0, 5))
            0: post(i, OP_LOAD, 8'hFF);
            1: post(i, OP_LOAD, 0);
            2: post(i, OP_LOAD, int'($urandom_range(0, MOD - 1)));
            default: post(i, 2'($urandom_range(0, 3)), int'($urandom_range(0, MOD - 1)));
          endcase
        end
      end
      serve(($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
            ($urandom_range(0, 3) == 0), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
